// File: rtl/leve1_trap_ctrl.sv
// leve1_trap_ctrl: M-mode trap-entry / MRET sequencer that also arbitrates the CSR file port
//    CLK, RST          clock; asynchronous active-high reset
//    TRAP_*, XRET_*    level-held requests, one-cycle ACK pulses
//    PIPE_CSR_*        execute-stage CSR port, passed through while idle
//    PIPE_STALL        pipeline hold while the sequencer owns the CSR port
//    CSR_*             CSR file port; CSR_RD arrives the cycle after CSR_RA
//    MODE              current privilege level
//    REDIRECT(_PC)     one-cycle fetch redirect and its target
module leve1_trap_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            TRAP_REQ,
   input  logic [XLEN-1:0] TRAP_CAUSE,
   input  logic [XLEN-1:0] TRAP_EPC,
   input  logic [XLEN-1:0] TRAP_TVAL,
   output logic            TRAP_ACK,
   input  logic            XRET_REQ,
   output logic            XRET_ACK,
   input  logic [11:0]     PIPE_CSR_RA,
   input  logic [1:0]      PIPE_CSR_WCMD,
   input  logic [11:0]     PIPE_CSR_WA,
   input  logic [XLEN-1:0] PIPE_CSR_WD,
   output logic            PIPE_STALL,
   output logic [11:0]     CSR_RA,
   input  logic [XLEN-1:0] CSR_RD,
   output logic [1:0]      CSR_WCMD,
   output logic [11:0]     CSR_WA,
   output logic [XLEN-1:0] CSR_WD,
   output logic [1:0]      MODE,
   output logic            REDIRECT,
   output logic [XLEN-1:0] REDIRECT_PC
);
   localparam logic [1:0] CSR_NONE  = 2'd0;
   localparam logic [1:0] CSR_WRITE = 2'd3;
   localparam logic [1:0] MODE_M    = 2'd3;
   localparam logic [1:0] MODE_U    = 2'd0;
   typedef enum logic [3:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_REDIR, X_RS, X_RE, X_WR, X_REDIR} state_t;
   state_t state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
   logic [XLEN-1:0] mstat_q, mstat_d, mtvec_q, mtvec_d;
   logic [1:0] mode_q, mode_d, mpp_q, mpp_d;
   logic [XLEN-1:0] base, vec_tgt, mst_trap, mst_ret;
   assign base    = {mtvec_q[XLEN-1:2], 2'b00};
   // vectored target: carry out of the XLEN-wide add is dropped
   assign vec_tgt = base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
   assign MODE    = mode_q;
   always_comb begin
      mst_trap        = mstat_q;
      mst_trap[7]     = mstat_q[3];
      mst_trap[3]     = 1'b0;
      mst_trap[12:11] = mode_q;
      mst_ret         = mstat_q;
      mst_ret[3]      = mstat_q[7];
      mst_ret[7]      = 1'b1;
      mst_ret[12:11]  = MODE_U;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
         mstat_q <= '0;
         mtvec_q <= '0;
         mode_q  <= MODE_M;
         mpp_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         tval_q  <= tval_d;
         mstat_q <= mstat_d;
         mtvec_q <= mtvec_d;
         mode_q  <= mode_d;
         mpp_q   <= mpp_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      epc_d       = epc_q;
      tval_d      = tval_q;
      mstat_d     = mstat_q;
      mtvec_d     = mtvec_q;
      mode_d      = mode_q;
      mpp_d       = mpp_q;
      TRAP_ACK    = 1'b0;
      XRET_ACK    = 1'b0;
      PIPE_STALL  = state_q != IDLE;
      CSR_RA      = '0;
      CSR_WCMD    = CSR_NONE;
      CSR_WA      = '0;
      CSR_WD      = '0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      case (state_q)
         IDLE: begin
            CSR_RA = PIPE_CSR_RA;
            CSR_WA = PIPE_CSR_WA;
            CSR_WD = PIPE_CSR_WD;
            // the faulting instruction does not commit, so its CSR write is dropped
            CSR_WCMD = TRAP_REQ ? CSR_NONE : PIPE_CSR_WCMD;
            if (TRAP_REQ) begin
               TRAP_ACK = 1'b1;
               cause_d  = TRAP_CAUSE;
               epc_d    = {TRAP_EPC[XLEN-1:1], 1'b0};
               tval_d   = TRAP_TVAL;
               state_d  = T_EPC;
            end else if (XRET_REQ) begin
               XRET_ACK = 1'b1;
               state_d  = X_RS;
            end
         end
         T_EPC: begin
            CSR_WCMD = CSR_WRITE;
            CSR_WA   = 12'h341;
            CSR_WD   = epc_q;
            CSR_RA   = 12'h300;
            state_d  = T_CAUSE;
         end
         T_CAUSE: begin
            CSR_WCMD = CSR_WRITE;
            CSR_WA   = 12'h342;
            CSR_WD   = cause_q;
            CSR_RA   = 12'h305;
            mstat_d  = CSR_RD;
            state_d  = T_TVAL;
         end
         T_TVAL: begin
            CSR_WCMD = CSR_WRITE;
            CSR_WA   = 12'h343;
            CSR_WD   = tval_q;
            mtvec_d  = CSR_RD;
            state_d  = T_STAT;
         end
         T_STAT: begin
            CSR_WCMD = CSR_WRITE;
            CSR_WA   = 12'h300;
            CSR_WD   = mst_trap;
            state_d  = T_REDIR;
         end
         T_REDIR: begin
            REDIRECT    = 1'b1;
            REDIRECT_PC = (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ? vec_tgt : base;
            mode_d      = MODE_M;
            state_d     = IDLE;
         end
         X_RS: begin
            CSR_RA  = 12'h300;
            state_d = X_RE;
         end
         X_RE: begin
            CSR_RA  = 12'h341;
            mstat_d = CSR_RD;
            state_d = X_WR;
         end
         X_WR: begin
            CSR_WCMD = CSR_WRITE;
            CSR_WA   = 12'h300;
            CSR_WD   = mst_ret;
            epc_d    = {CSR_RD[XLEN-1:1], 1'b0};
            mpp_d    = mstat_q[12:11];
            state_d  = X_REDIR;
         end
         X_REDIR: begin
            REDIRECT    = 1'b1;
            REDIRECT_PC = epc_q;
            mode_d      = mpp_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // while reset is held the idle pass-through and request acks are masked too
      if (RST) begin
         TRAP_ACK   = 1'b0;
         XRET_ACK   = 1'b0;
         PIPE_STALL = 1'b0;
         CSR_RA     = '0;
         CSR_WCMD   = CSR_NONE;
         CSR_WA     = '0;
         CSR_WD     = '0;
      end
   end
endmodule

// File: tb/tb_leve1_trap_ctrl.sv
// tb_leve1_trap_ctrl: directed bench for the trap/MRET sequencer with a tiny CSR read model
module tb_leve1_trap_ctrl;
   logic        CLK, RST, TRAP_REQ, TRAP_ACK, XRET_REQ, XRET_ACK, PIPE_STALL, REDIRECT;
   logic [63:0] TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, PIPE_CSR_WD, CSR_RD, CSR_WD, REDIRECT_PC;
   logic [11:0] PIPE_CSR_RA, PIPE_CSR_WA, CSR_RA, CSR_WA;
   logic [1:0]  PIPE_CSR_WCMD, CSR_WCMD, MODE;
   logic [63:0] mstatus_m, mtvec_m, mepc_m;
   int checks = 0;
   int failures = 0;
   leve1_trap_ctrl #(.XLEN(64)) dut (
      .CLK(CLK), .RST(RST),
      .TRAP_REQ(TRAP_REQ), .TRAP_CAUSE(TRAP_CAUSE), .TRAP_EPC(TRAP_EPC), .TRAP_TVAL(TRAP_TVAL), .TRAP_ACK(TRAP_ACK),
      .XRET_REQ(XRET_REQ), .XRET_ACK(XRET_ACK),
      .PIPE_CSR_RA(PIPE_CSR_RA), .PIPE_CSR_WCMD(PIPE_CSR_WCMD), .PIPE_CSR_WA(PIPE_CSR_WA), .PIPE_CSR_WD(PIPE_CSR_WD),
      .PIPE_STALL(PIPE_STALL),
      .CSR_RA(CSR_RA), .CSR_RD(CSR_RD), .CSR_WCMD(CSR_WCMD), .CSR_WA(CSR_WA), .CSR_WD(CSR_WD),
      .MODE(MODE), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
   );
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   always @(posedge CLK)
      CSR_RD <= CSR_RA == 12'h300 ? mstatus_m : CSR_RA == 12'h305 ? mtvec_m : CSR_RA == 12'h341 ? mepc_m : 64'h0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic pipe(input logic [11:0] ra, input logic [1:0] cmd, input logic [11:0] wa, input logic [63:0] wd);
      PIPE_CSR_RA = ra;
      PIPE_CSR_WCMD = cmd;
      PIPE_CSR_WA = wa;
      PIPE_CSR_WD = wd;
   endtask
   task automatic trap(input logic [63:0] c, input logic [63:0] e, input logic [63:0] t);
      TRAP_REQ = 1'b1;
      TRAP_CAUSE = c;
      TRAP_EPC = e;
      TRAP_TVAL = t;
   endtask
   initial begin
      RST = 1'b1;
      TRAP_REQ = 1'b0;
      XRET_REQ = 1'b0;
      TRAP_CAUSE = '0;
      TRAP_EPC = '0;
      TRAP_TVAL = '0;
      mstatus_m = '0;
      mtvec_m = '0;
      mepc_m = '0;
      pipe(12'h305, 2'd3, 12'h305, 64'h8000_0000);
      #2;
      chk("rst_wcmd", CSR_WCMD, 2'd0);
      chk("rst_wa", CSR_WA, 12'h0);
      chk("rst_wd", CSR_WD, 64'h0);
      chk("rst_ra", CSR_RA, 12'h0);
      chk("rst_stall", PIPE_STALL, 1'b0);
      chk("rst_mode", MODE, 2'd3);
      chk("rst_redir", REDIRECT, 1'b0);
      chk("rst_pc", REDIRECT_PC, 64'h0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("pt_wcmd", CSR_WCMD, 2'd3);
      chk("pt_wa", CSR_WA, 12'h305);
      chk("pt_wd", CSR_WD, 64'h8000_0000);
      chk("pt_ra", CSR_RA, 12'h305);
      chk("pt_stall", PIPE_STALL, 1'b0);
      chk("pt_ack", TRAP_ACK, 1'b0);
      // direct trap
      @(negedge CLK);
      pipe(12'h0, 2'd0, 12'h0, 64'h0);
      mstatus_m = 64'h8;
      mtvec_m = 64'h8000_0100;
      trap(64'd2, 64'h8000_0043, 64'hdead);
      #1;
      chk("td_ack", TRAP_ACK, 1'b1);
      chk("td_ack_stall", PIPE_STALL, 1'b0);
      @(negedge CLK);
      TRAP_REQ = 1'b0;
      #1;
      chk("td_ack_pulse", TRAP_ACK, 1'b0);
      chk("td_stall", PIPE_STALL, 1'b1);
      chk("td_epc_cmd", CSR_WCMD, 2'd3);
      chk("td_epc_wa", CSR_WA, 12'h341);
      chk("td_epc_wd", CSR_WD, 64'h8000_0042);
      chk("td_epc_ra", CSR_RA, 12'h300);
      @(negedge CLK);
      #1;
      chk("td_cause_wa", CSR_WA, 12'h342);
      chk("td_cause_wd", CSR_WD, 64'd2);
      chk("td_cause_ra", CSR_RA, 12'h305);
      @(negedge CLK);
      #1;
      chk("td_tval_wa", CSR_WA, 12'h343);
      chk("td_tval_wd", CSR_WD, 64'hdead);
      @(negedge CLK);
      #1;
      chk("td_stat_cmd", CSR_WCMD, 2'd3);
      chk("td_stat_wa", CSR_WA, 12'h300);
      chk("td_stat_wd", CSR_WD, 64'h1880);
      chk("td_stat_redir", REDIRECT, 1'b0);
      @(negedge CLK);
      #1;
      chk("td_redir", REDIRECT, 1'b1);
      chk("td_pc", REDIRECT_PC, 64'h8000_0100);
      chk("td_redir_cmd", CSR_WCMD, 2'd0);
      @(negedge CLK);
      #1;
      chk("td_redir_pulse", REDIRECT, 1'b0);
      chk("td_mode", MODE, 2'd3);
      chk("td_idle_stall", PIPE_STALL, 1'b0);
      // MRET
      mstatus_m = 64'h880;
      mepc_m = 64'h8020_0000;
      XRET_REQ = 1'b1;
      #1;
      chk("xr_ack", XRET_ACK, 1'b1);
      chk("xr_tack", TRAP_ACK, 1'b0);
      @(negedge CLK);
      XRET_REQ = 1'b0;
      #1;
      chk("xr_ack_pulse", XRET_ACK, 1'b0);
      chk("xr_rs_ra", CSR_RA, 12'h300);
      chk("xr_rs_cmd", CSR_WCMD, 2'd0);
      chk("xr_stall", PIPE_STALL, 1'b1);
      @(negedge CLK);
      #1;
      chk("xr_re_ra", CSR_RA, 12'h341);
      @(negedge CLK);
      #1;
      chk("xr_wr_cmd", CSR_WCMD, 2'd3);
      chk("xr_wr_wa", CSR_WA, 12'h300);
      chk("xr_wr_wd", CSR_WD, 64'h88);
      @(negedge CLK);
      #1;
      chk("xr_redir", REDIRECT, 1'b1);
      chk("xr_pc", REDIRECT_PC, 64'h8020_0000);
      @(negedge CLK);
      #1;
      chk("xr_mode", MODE, 2'd1);
      chk("xr_redir_pulse", REDIRECT, 1'b0);
      // reset in the middle of a trap, with a pipeline write pending
      pipe(12'h342, 2'd1, 12'h300, 64'hff);
      trap(64'd5, 64'h100, 64'h0);
      #1;
      chk("rm_ack", TRAP_ACK, 1'b1);
      chk("rm_suppress", CSR_WCMD, 2'd0);
      @(negedge CLK);
      TRAP_REQ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      chk("rm_tval_wa", CSR_WA, 12'h343);
      RST = 1'b1;
      #1;
      chk("rm_wcmd", CSR_WCMD, 2'd0);
      chk("rm_wa", CSR_WA, 12'h0);
      chk("rm_wd", CSR_WD, 64'h0);
      chk("rm_ra", CSR_RA, 12'h0);
      chk("rm_stall", PIPE_STALL, 1'b0);
      chk("rm_mode", MODE, 2'd3);
      chk("rm_redir", REDIRECT, 1'b0);
      // vectored trap right after reset release
      @(negedge CLK);
      RST = 1'b0;
      pipe(12'h0, 2'd0, 12'h0, 64'h0);
      mstatus_m = 64'h8;
      mtvec_m = 64'h8000_0101;
      trap(64'h8000_0000_0000_0007, 64'h8000_0200, 64'h0);
      #1;
      chk("tv_ack", TRAP_ACK, 1'b1);
      @(negedge CLK);
      TRAP_REQ = 1'b0;
      #1;
      chk("tv_epc_wd", CSR_WD, 64'h8000_0200);
      @(negedge CLK);
      #1;
      chk("tv_cause_wd", CSR_WD, 64'h8000_0000_0000_0007);
      @(negedge CLK);
      @(negedge CLK);
      #1;
      chk("tv_stat_wd", CSR_WD, 64'h1880);
      @(negedge CLK);
      #1;
      chk("tv_redir", REDIRECT, 1'b1);
      chk("tv_pc", REDIRECT_PC, 64'h8000_011C);
      // simultaneous trap and MRET with a pipeline write pending
      @(negedge CLK);
      mstatus_m = 64'h880;
      mtvec_m = 64'h8000_0100;
      mepc_m = 64'h8020_0000;
      pipe(12'h0, 2'd3, 12'h305, 64'h1234);
      trap(64'd2, 64'h8000_0010, 64'h0);
      XRET_REQ = 1'b1;
      #1;
      chk("sim_tack", TRAP_ACK, 1'b1);
      chk("sim_xack", XRET_ACK, 1'b0);
      chk("sim_suppress", CSR_WCMD, 2'd0);
      @(negedge CLK);
      TRAP_REQ = 1'b0;
      #1;
      chk("sim_xack_hold", XRET_ACK, 1'b0);
      chk("sim_epc_wa", CSR_WA, 12'h341);
      repeat (3) @(negedge CLK);
      #1;
      chk("sim_stat_wd", CSR_WD, 64'h1800);
      @(negedge CLK);
      #1;
      chk("sim_redir", REDIRECT, 1'b1);
      chk("sim_pc", REDIRECT_PC, 64'h8000_0100);
      chk("sim_redir_xack", XRET_ACK, 1'b0);
      @(negedge CLK);
      #1;
      chk("sim_xret_ack", XRET_ACK, 1'b1);
      chk("sim_xret_pass", CSR_WCMD, 2'd3);
      chk("sim_xret_wa", CSR_WA, 12'h305);
      @(negedge CLK);
      XRET_REQ = 1'b0;
      pipe(12'h0, 2'd0, 12'h0, 64'h0);
      repeat (3) @(negedge CLK);
      #1;
      chk("sim_xr_redir", REDIRECT, 1'b1);
      chk("sim_xr_pc", REDIRECT_PC, 64'h8020_0000);
      @(negedge CLK);
      #1;
      chk("sim_xr_mode", MODE, 2'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/leve1_trap_ctrl.md
Name: leve1_trap_ctrl

Overview:
- M-mode trap-entry and MRET sequencer that owns the LEVE1 CSR file read and write ports.
- On a trap it writes mepc, mcause, mtval and mstatus one per cycle, reads mtvec, then redirects fetch. On MRET it restores mstatus and the privilege mode, then redirects fetch to mepc.
- When idle it passes the execute-stage CSR port straight through, so it also acts as the CSR-port arbiter.

Parameters:
XLEN, 64, data width (matches `XLEN)

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
TRAP_REQ  in  1  trap request, level-held until TRAP_ACK
TRAP_CAUSE  in  XLEN  mcause value; bit XLEN-1 = interrupt
TRAP_EPC  in  XLEN  faulting PC
TRAP_TVAL  in  XLEN  mtval value
TRAP_ACK  out  1  one-cycle accept pulse
XRET_REQ  in  1  MRET request, level-held until XRET_ACK
XRET_ACK  out  1  one-cycle accept pulse
PIPE_CSR_RA  in  12  pipeline CSR read address
PIPE_CSR_WCMD  in  2  pipeline write cmd (CSR_NONE/SET/CLEAR/WRITE)
PIPE_CSR_WA  in  12  pipeline write address
PIPE_CSR_WD  in  XLEN  pipeline write data
PIPE_STALL  out  1  pipeline must hold; CSR port is owned by the controller
CSR_RA  out  12  to CSR file; CSR_RD is valid on the cycle after CSR_RA
CSR_RD  in  XLEN  registered read data
CSR_WCMD  out  2  to CSR file
CSR_WA  out  12  to CSR file
CSR_WD  out  XLEN  to CSR file
MODE  out  2  current privilege level
REDIRECT  out  1  one-cycle fetch redirect pulse
REDIRECT_PC  out  XLEN  redirect target; valid only while REDIRECT=1

Behaviour:
- Reset (asynchronous; also honoured mid-sequence):
  - state IDLE, MODE=`MODE_M, all latches 0.
  - TRAP_ACK, XRET_ACK, REDIRECT, PIPE_STALL = 0; REDIRECT_PC = 0.
  - CSR_WCMD=`CSR_NONE, CSR_WA=0, CSR_WD=0, CSR_RA=0.
  - Any partial sequence is abandoned; CSR contents are not repaired.
- IDLE:
  - CSR_RA=PIPE_CSR_RA; CSR_WCMD/WA/WD = PIPE_CSR_*; PIPE_STALL=0.
  - TRAP_REQ=1: TRAP_ACK=1, latch cause/epc/tval, go to T_EPC. The pipeline write this cycle is suppressed (CSR_WCMD=CSR_NONE) because the faulting instruction does not commit.
  - Else XRET_REQ=1: XRET_ACK=1, pipeline write passes through, go to X_RS.
  - TRAP_REQ and XRET_REQ together: trap wins, XRET_REQ is ignored (not acked).
- All non-IDLE states: PIPE_STALL=1; pipeline CSR inputs are ignored; requests are not re-sampled.
- Trap sequence, each state one cycle:
  - T_EPC: write 0x341 = {epc[XLEN-1:1],0}; CSR_RA=0x300.
  - T_CAUSE: write 0x342 = cause; capture mstatus from CSR_RD; CSR_RA=0x305.
  - T_TVAL: write 0x343 = tval; capture mtvec from CSR_RD.
  - T_STAT: CSR_WRITE 0x300 = captured mstatus with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=MODE.
  - T_REDIR: REDIRECT=1; MODE<=`MODE_M on exit; go to IDLE.
    - Target when mtvec[1:0]==01 and cause[XLEN-1]=1: {mtvec[XLEN-1:2],2'b00} + (cause[5:0]<<2). Arithmetic is XLEN wide; carry out is discarded.
    - Otherwise: {mtvec[XLEN-1:2],2'b00}. Modes 10/11 are treated as direct.
- MRET sequence:
  - X_RS: CSR_RA=0x300.
  - X_RE: capture mstatus; CSR_RA=0x341.
  - X_WR: capture mepc; CSR_WRITE 0x300 with MIE=old MPIE, MPIE=1, MPP=`MODE_U (00); latch old MPP.
  - X_REDIR: REDIRECT=1, REDIRECT_PC={mepc[XLEN-1:1],0}; MODE<=latched MPP; go to IDLE.
- Latency:
  - Trap: REDIRECT 5 cycles after the ACK cycle.
  - MRET: REDIRECT 4 cycles after the ACK cycle.
  - A new request can be accepted the cycle after REDIRECT.
- Non-write states drive CSR_WCMD=`CSR_NONE, CSR_WA=0, CSR_WD=0.
- All outputs are registered or decoded from state only; no combinational path from TRAP_REQ/XRET_REQ to CSR_W*, except the IDLE pass-through/suppress mux.

Test Plan:
- Reset mid-trap (assert RST in T_TVAL) -> outputs zero the same cycle, MODE=11, IDLE; a following TRAP_REQ is acked normally.
- IDLE pass-through: PIPE_CSR_WCMD=WRITE, WA=0x305, WD=0x8000_0000 -> identical on CSR_W* that cycle, PIPE_STALL=0.
- Trap direct:
  - Stimulus: mtvec=0x8000_0100, mstatus=0x8 (MIE=1), MODE=11, cause=2, epc=0x8000_0043, tval=0xdead.
  - Writes: 0x341=0x8000_0042, 0x342=2, 0x343=0xdead, 0x300=0x1880.
  - REDIRECT_PC=0x8000_0100 five cycles after ACK.
- Trap vectored: mtvec=0x8000_0101, cause=0x8000_0000_0000_0007 -> REDIRECT_PC=0x8000_011C.
- MRET: mstatus=0x880 (MPIE=1, MPP=01), mepc=0x8020_0000 -> write 0x300=0x88, MODE=01, REDIRECT_PC=0x8020_0000 four cycles after ACK.
- Simultaneous TRAP_REQ+XRET_REQ with a pipeline write pending -> only TRAP_ACK; CSR_WCMD=NONE in the accept cycle; trap sequence runs; XRET is accepted after return to IDLE.
